// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem router: FSM encoding, default
// timeout, the error read-data pattern and the saturating counter helper.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int          DEFAULT_TIMEOUT = 255;
  localparam int          TCNT_W          = 16;
  localparam logic [31:0] ERR_DATA        = 32'hFFFF_FFFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/iomem_addr_decode.sv
// Combinational address decoder: one-hot hit vector (lowest channel index
// wins on overlapping windows) plus a miss flag.
module iomem_addr_decode #(
  parameter int                     NUM_CH = 4,
  parameter logic [NUM_CH*32-1:0]   BASE   = '0,
  parameter logic [NUM_CH*32-1:0]   MASK   = '0
) (
  input  logic [31:0]       addr,
  output logic [NUM_CH-1:0] hit,
  output logic              miss
);

  logic found;

  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && ((addr & MASK[32*k +: 32]) == BASE[32*k +: 32])) begin
        hit[k] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/iomem_router.sv
// Routes a single-outstanding iomem request to one of NUM_CH peripheral
// channels, with decode-miss and ready-timeout error reporting.
module iomem_router
  import iomem_pkg::*;
#(
  parameter int                   NUM_CH  = 4,
  parameter logic [NUM_CH*32-1:0] BASE    = {32'h0300_3000, 32'h0300_2000,
                                             32'h0300_1000, 32'h0300_0000},
  parameter logic [NUM_CH*32-1:0] MASK    = {32'hFFFF_FF00, 32'hFFFF_FF00,
                                             32'hFFFF_FFFC, 32'hFFFF_FFFC},
  parameter int                   TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   iomem_valid,
  output logic                   iomem_ready,
  input  logic [3:0]             iomem_wstrb,
  input  logic [31:0]            iomem_addr,
  input  logic [31:0]            iomem_wdata,
  output logic [31:0]            iomem_rdata,
  output logic [NUM_CH-1:0]      ch_valid,
  input  logic [NUM_CH-1:0]      ch_ready,
  output logic [3:0]             ch_wstrb,
  output logic [31:0]            ch_addr,
  output logic [31:0]            ch_wdata,
  input  logic [NUM_CH*32-1:0]   ch_rdata,
  output logic                   err_irq,
  output logic [7:0]             err_cnt,
  output logic [31:0]            err_addr,
  output logic [1:0]             fsm_state
);

  // Handshake: a request is taken in IDLE when iomem_valid=1 and the previous
  // completion pulse (iomem_ready) is low; iomem_ready is a one-cycle pulse
  // registered from the RESP state, with iomem_rdata valid from that cycle on.
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_t              state, next_state;
  logic [NUM_CH-1:0]   hit;
  logic                miss;
  logic [TCNT_W-1:0]   tcnt;
  logic [31:0]         resp_data;
  logic [31:0]         sel_rdata;
  logic                sel_ready;
  logic                timeout_hit;
  logic                accept;
  logic                access_done;
  logic                access_to;
  logic                err_set;

  iomem_addr_decode #(
    .NUM_CH (NUM_CH),
    .BASE   (BASE),
    .MASK   (MASK)
  ) u_decode (
    .addr (iomem_addr),
    .hit  (hit),
    .miss (miss)
  );

  // ch_valid is one-hot, so it doubles as the read-data and ready select.
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_valid[k]) sel_rdata = ch_rdata[32*k +: 32];
    end
  end

  assign sel_ready   = |(ch_ready & ch_valid);
  assign timeout_hit = (tcnt == TCNT_LAST);
  assign fsm_state   = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (iomem_valid && !iomem_ready) next_state = miss ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_ready || timeout_hit) next_state = ST_RESP;
      end
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    accept      = (state == ST_IDLE) && iomem_valid && !iomem_ready;
    access_done = (state == ST_ACCESS) && sel_ready;
    access_to   = (state == ST_ACCESS) && !sel_ready && timeout_hit;
    err_set     = (accept && miss) || access_to;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ch_valid    <= '0;
      ch_addr     <= '0;
      ch_wdata    <= '0;
      ch_wstrb    <= '0;
      tcnt        <= '0;
      resp_data   <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      err_irq     <= 1'b0;
      err_cnt     <= '0;
      err_addr    <= '0;
    end else begin
      if (accept) begin
        ch_addr  <= iomem_addr;
        ch_wdata <= iomem_wdata;
        ch_wstrb <= iomem_wstrb;
        tcnt     <= '0;
        if (miss) resp_data <= ERR_DATA;
        else      ch_valid  <= hit;
      end
      if (state == ST_ACCESS) tcnt <= tcnt + 1'b1;
      if (access_done) begin
        resp_data <= sel_rdata;
        ch_valid  <= '0;
      end
      if (access_to) begin
        resp_data <= ERR_DATA;
        ch_valid  <= '0;
      end
      iomem_ready <= (state == ST_RESP);
      if (state == ST_RESP) iomem_rdata <= resp_data;
      err_irq <= err_set;
      if (err_set) begin
        err_addr <= accept ? iomem_addr : ch_addr;
        err_cnt  <= sat_inc(err_cnt);
      end
    end
  end

endmodule
